connect4_drop_ctrl: RTL and testbench
=====================================

Name: connect4_drop_ctrl

Overview:
Sequences every token drop into the Connect 4 board. It accepts column requests from the FPGA player (P1) and the Arduino player (P2), and picks a column itself when `random_move` is raised on turn timeout. It tracks per-column fill heights, drives the falling-token animation, and issues one board write per move. It sits between connect4_fsm and the board matrix/VGA renderer. Its `drop_done` pulse is the game FSM's move-complete indication.

Parameters:
COLS, 7, number of board columns (4..8).
ROWS, 6, number of board rows (1..8).
FALL_TICKS, 2_500_000, clock cycles the animated token spends on each row (≥1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous board clear for a new game; aborts any in-flight move
p1_turn  in  1  P1 owns the turn (from connect4_fsm)
p2_turn  in  1  P2 owns the turn (from connect4_fsm)
p1_req  in  1  1-cycle P1 drop request
p1_col  in  3  P1 column
p2_req  in  1  1-cycle P2 (Arduino) drop request
p2_col  in  3  P2 column
random_move  in  1  timeout; controller picks the column
busy  out  1  high in any state except IDLE
fall_active  out  1  high during FALL
fall_row  out  3  row of the animated token (0 = top)
fall_col  out  3  column of the animated token
fall_player  out  2  owner of the animated token
wr_en  out  1  1-cycle board write strobe
wr_row  out  3  landing row
wr_col  out  3  landing column
wr_player  out  2  01 = P1, 10 = P2
drop_done  out  1  1-cycle pulse, move committed
drop_invalid  out  1  1-cycle pulse, request rejected
board_full  out  1  all columns hold ROWS tokens

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; all heights are 0; the LFSR loads 8'hA5.
  - Every output is 0.
- clear (synchronous, highest priority below reset):
  - Same effect as reset, except the LFSR keeps running.
  - An in-flight move produces no wr_en and no drop_done.
- Turn owner:
  - p1_turn has priority if both turn inputs are high.
  - With neither turn input high, every request is ignored.
- Request sampling:
  - Requests are sampled only in IDLE. Requests arriving while busy are dropped, never queued.
  - A request from the non-owning player is ignored.
  - random_move has priority over a simultaneous owner request.
- States:
  - IDLE: on an accepted request, latch col and player, then go to CHECK. On random_move, latch player, set col = lfsr[2:0] (minus COLS if ≥ COLS), then go to SEARCH.
  - SEARCH: one column per cycle. If heights[col] < ROWS, go to CHECK; otherwise col = (col+1) mod COLS. If board_full, pulse drop_invalid and go to IDLE.
  - CHECK (1 cycle):
    - If col ≥ COLS or heights[col] == ROWS, pulse drop_invalid and go to IDLE.
    - Otherwise land = ROWS-1-heights[col], fall_row = 0, and go to FALL.
  - FALL:
    - fall_row holds each row for FALL_TICKS cycles, including the landing row. Total length is (land+1)*FALL_TICKS cycles.
    - After the last tick at fall_row == land, go to WRITE.
  - WRITE (1 cycle):
    - wr_en = 1, with wr_row = land, wr_col = col, wr_player = latched player.
    - heights[col] increments; go to DONE.
  - DONE (1 cycle): drop_done = 1, then go to IDLE.
- Latency: from the sampling edge of an owner request to wr_en is 2 + (land+1)*FALL_TICKS cycles. drop_done follows wr_en by one cycle.
- Height counters: 4 bits each, saturating at ROWS; they never wrap.
- board_full: registered. It rises the cycle after the write that fills the last cell, and clears on clear or reset.
- Outputs outside FALL/WRITE: fall_row, fall_col, fall_player, wr_row, wr_col and wr_player are driven to 0.
- LFSR: 8-bit, free-running every cycle regardless of state.

Decomposition:
- connect4_pkg holds:
  - COLS_DEF and ROWS_DEF.
  - Player encoding: EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10.
  - drop_state_t enum: IDLE, SEARCH, CHECK, FALL, WRITE, DONE.
- One sub-module, connect4_lfsr: 8-bit Galois LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, enable input, never all-zero.

Test Plan (FALL_TICKS = 2):
1. Reset check: assert rst_n low mid-run, then release → all outputs 0, board_full = 0. A P1 drop into col 0 lands at row 5.
2. P1 drop on an empty board: p1_turn = 1, p1_req with p1_col = 3 → fall_row steps 0..5, 2 cycles each. wr_en comes 14 cycles after the sample edge with row 5, col 3, player 01. drop_done comes at cycle 15.
3. Full column: six P2 drops into col 2 land at rows 5,4,3,2,1,0; the row-0 drop spends 2 cycles in FALL. A seventh request → drop_invalid 2 cycles after sampling, no wr_en. Request col 7 → drop_invalid.
4. Arbitration:
   - p2_req while only p1_turn = 1 → no response.
   - p1_req and random_move in the same cycle → random path taken.
   - p1_req during FALL → ignored; exactly one wr_en occurs.
5. Random move skipping full columns: fill cols 0..5, then random_move under p2_turn → wr_col = 6, wr_row = 5, wr_player = 10.
6. Board full and clear mid-move:
   - Fill all 42 cells → board_full rises the cycle after the 42nd wr_en. A following random_move → drop_invalid.
   - Assert clear during FALL → no wr_en, no drop_done, busy = 0 next cycle, heights reset.

Source files
------------

// File: rtl/connect4_pkg.sv
// connect4_pkg: shared board dimensions, player codes and drop-controller states
package connect4_pkg;
  localparam int COLS_DEF = 7;
  localparam int ROWS_DEF = 6;
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;
  typedef enum logic [2:0] {IDLE, SEARCH, CHECK, FALL, WRITE, DONE} drop_state_t;
endpackage

// File: rtl/connect4_lfsr.sv
// connect4_lfsr: free-running 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), seed 8'hA5, exposes low 3 bits
module connect4_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [2:0] q
);
  logic [7:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = en ? ({1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00)) : lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 8'hA5;
    else lfsr_q <= lfsr_d;
  assign q = lfsr_q[2:0];
endmodule

// File: rtl/connect4_drop_ctrl.sv
// connect4_drop_ctrl: arbitrates drop requests, searches/validates the column, animates the fall and commits one board write
module connect4_drop_ctrl
  import connect4_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int FALL_TICKS = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       p1_turn,
  input  logic       p2_turn,
  input  logic       p1_req,
  input  logic [2:0] p1_col,
  input  logic       p2_req,
  input  logic [2:0] p2_col,
  input  logic       random_move,
  output logic       busy,
  output logic       fall_active,
  output logic [2:0] fall_row,
  output logic [2:0] fall_col,
  output logic [1:0] fall_player,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [1:0] wr_player,
  output logic       drop_done,
  output logic       drop_invalid,
  output logic       board_full
);
  localparam int TW = FALL_TICKS > 1 ? $clog2(FALL_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FALL_TICKS - 1);
  localparam logic [3:0] NCOL = 4'(COLS);
  localparam logic [3:0] NROW = 4'(ROWS);
  drop_state_t state_q, state_d;
  logic [2:0] col_q, col_d, land_q, land_d, row_q, row_d;
  logic [1:0] player_q, player_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] height_q [8];
  logic [3:0] height_d [8];
  logic full_q, full_d, inv_q, inv_d;
  logic [2:0] rnd;
  logic [1:0] owner;
  logic owner_req;
  logic [2:0] owner_col, rnd_col;
  logic [3:0] h;
  connect4_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .en(1'b1), .q(rnd));
  assign owner = p1_turn ? P1 : p2_turn ? P2 : EMPTY;
  assign owner_req = p1_turn ? p1_req : p2_turn & p2_req;
  assign owner_col = p1_turn ? p1_col : p2_col;
  assign rnd_col = {1'b0, rnd} >= NCOL ? rnd - NCOL[2:0] : rnd;
  assign h = height_q[col_q];
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    player_d = player_q;
    land_d = land_q;
    row_d = row_q;
    tick_d = tick_q;
    height_d = height_q;
    inv_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      col_d = '0;
      player_d = EMPTY;
      land_d = '0;
      row_d = '0;
      tick_d = '0;
      for (int i = 0; i < 8; i++) height_d[i] = '0;
    end else
      case (state_q)
        IDLE:
          if (owner != EMPTY && random_move) begin
            player_d = owner;
            col_d = rnd_col;
            state_d = SEARCH;
          end else if (owner_req) begin
            player_d = owner;
            col_d = owner_col;
            state_d = CHECK;
          end
        SEARCH:
          if (full_q) begin
            inv_d = 1'b1;
            state_d = IDLE;
          end else if (h < NROW) state_d = CHECK;
          else col_d = {1'b0, col_q} == NCOL - 4'd1 ? '0 : col_q + 3'd1;
        CHECK:
          if ({1'b0, col_q} >= NCOL || h >= NROW) begin
            inv_d = 1'b1;
            state_d = IDLE;
          end else begin
            land_d = 3'(NROW - 4'd1 - h);
            row_d = '0;
            tick_d = '0;
            state_d = FALL;
          end
        FALL:
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (row_q == land_q) state_d = WRITE;
            else row_d = row_q + 3'd1;
          end else tick_d = tick_q + 1'b1;
        WRITE: begin
          height_d[col_q] = h < NROW ? h + 4'd1 : h;
          state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    full_d = 1'b1;
    for (int i = 0; i < COLS; i++) full_d &= height_d[i] == NROW;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      col_q <= '0;
      player_q <= EMPTY;
      land_q <= '0;
      row_q <= '0;
      tick_q <= '0;
      for (int i = 0; i < 8; i++) height_q[i] <= '0;
      full_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      player_q <= player_d;
      land_q <= land_d;
      row_q <= row_d;
      tick_q <= tick_d;
      height_q <= height_d;
      full_q <= full_d;
      inv_q <= inv_d;
    end
  assign busy = state_q != IDLE;
  assign fall_active = state_q == FALL;
  assign fall_row = fall_active ? row_q : '0;
  assign fall_col = fall_active ? col_q : '0;
  assign fall_player = fall_active ? player_q : EMPTY;
  assign wr_en = state_q == WRITE;
  assign wr_row = wr_en ? land_q : '0;
  assign wr_col = wr_en ? col_q : '0;
  assign wr_player = wr_en ? player_q : EMPTY;
  assign drop_done = state_q == DONE;
  assign drop_invalid = inv_q;
  assign board_full = full_q;
endmodule

// File: tb/tb_connect4_drop_ctrl.sv
// tb_connect4_drop_ctrl: vector table, directed corner sequences and randomized moves against a heights-array model
module tb_connect4_drop_ctrl;
  import connect4_pkg::*;
  localparam int FT = 2;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic p1_turn = 1'b0, p2_turn = 1'b0, p1_req = 1'b0, p2_req = 1'b0, random_move = 1'b0;
  logic [2:0] p1_col = '0, p2_col = '0;
  logic busy, fall_active, wr_en, drop_done, drop_invalid, board_full;
  logic [2:0] fall_row, fall_col, wr_row, wr_col;
  logic [1:0] fall_player, wr_player;
  logic [21:0] outs;
  typedef struct {
    logic t1, t2, r1, r2, rm;
    logic [2:0] c1, c2;
    logic ew, ei;
    logic [2:0] erow, ecol;
    logic [1:0] epl;
  } vec_t;
  typedef struct {
    int wr_cyc, inv_cyc, done_cyc, n_wr, n_busy, fall_n, ferr, zerr;
    int row, col, pl, fcol, fpl, bf_wr, bf_done;
  } res_t;
  int n_chk = 0, n_fail = 0;
  int h[7];
  vec_t tbl[16];
  connect4_drop_ctrl #(.COLS(7), .ROWS(6), .FALL_TICKS(FT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .p1_turn(p1_turn), .p2_turn(p2_turn),
    .p1_req(p1_req), .p1_col(p1_col), .p2_req(p2_req), .p2_col(p2_col), .random_move(random_move),
    .busy(busy), .fall_active(fall_active), .fall_row(fall_row), .fall_col(fall_col),
    .fall_player(fall_player), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_player(wr_player), .drop_done(drop_done), .drop_invalid(drop_invalid), .board_full(board_full)
  );
  assign outs = {busy, fall_active, fall_row, fall_col, fall_player, wr_en, wr_row, wr_col,
                 wr_player, drop_done, drop_invalid, board_full};
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input int t1, t2, r1, r2, rm, c1, c2, ew, ei, erow, ecol, epl);
    vec_t v;
    v.t1 = 1'(t1); v.t2 = 1'(t2); v.r1 = 1'(r1); v.r2 = 1'(r2); v.rm = 1'(rm);
    v.c1 = 3'(c1); v.c2 = 3'(c2); v.ew = 1'(ew); v.ei = 1'(ei);
    v.erow = 3'(erow); v.ecol = 3'(ecol); v.epl = 2'(epl);
    return v;
  endfunction
  function automatic int model_full();
    int f = 1;
    for (int c = 0; c < 7; c++) if (h[c] != 6) f = 0;
    return f;
  endfunction
  function automatic vec_t predict(input vec_t v, output bit any);
    vec_t e = v;
    int own, col;
    e.ew = 1'b0; e.ei = 1'b0; e.erow = '0; e.ecol = '0; e.epl = '0; any = 1'b0;
    own = v.t1 ? 1 : v.t2 ? 2 : 0;
    if (own == 0) return e;
    e.epl = 2'(own);
    if (v.rm) begin
      if (model_full() != 0) e.ei = 1'b1;
      else begin e.ew = 1'b1; any = 1'b1; end
      return e;
    end
    if (own == 1 ? !v.r1 : !v.r2) return e;
    col = own == 1 ? int'(v.c1) : int'(v.c2);
    if (col >= 7 || h[col] >= 6) e.ei = 1'b1;
    else begin e.ew = 1'b1; e.ecol = 3'(col); e.erow = 3'(5 - h[col]); end
    return e;
  endfunction
  task automatic run(input vec_t v, input int lim, input int inj, output res_t r);
    int stop = lim;
    r.wr_cyc = -1; r.inv_cyc = -1; r.done_cyc = -1; r.n_wr = 0; r.n_busy = 0; r.fall_n = 0;
    r.ferr = 0; r.zerr = 0; r.row = 0; r.col = 0; r.pl = 0; r.fcol = 0; r.fpl = 0; r.bf_wr = 0; r.bf_done = 0;
    p1_turn = v.t1; p2_turn = v.t2; p1_req = v.r1; p2_req = v.r2; random_move = v.rm;
    p1_col = v.c1; p2_col = v.c2;
    for (int i = 1; i <= stop; i++) begin
      @(negedge clk);
      p1_req = 1'b0; p2_req = 1'b0; random_move = 1'b0;
      if (i == inj) begin p1_req = 1'b1; p1_col = 3'd6; end
      if (busy) r.n_busy++;
      if (wr_en) begin
        r.n_wr++;
        if (r.wr_cyc < 0) begin
          r.wr_cyc = i; r.row = wr_row; r.col = wr_col; r.pl = wr_player; r.bf_wr = board_full;
        end
      end else if (wr_row != 0 || wr_col != 0 || wr_player != 0) r.zerr++;
      if (fall_active) begin
        if (int'(fall_row) != r.fall_n / FT) r.ferr++;
        if (r.fall_n == 0) begin r.fcol = fall_col; r.fpl = fall_player; end
        else if (int'(fall_col) != r.fcol || int'(fall_player) != r.fpl) r.ferr++;
        r.fall_n++;
      end else if (fall_row != 0 || fall_col != 0 || fall_player != 0) r.zerr++;
      if (drop_done && r.done_cyc < 0) begin r.done_cyc = i; r.bf_done = board_full; end
      if (drop_invalid && r.inv_cyc < 0) r.inv_cyc = i;
      if ((drop_done || drop_invalid) && stop > i + 4) stop = i + 4;
    end
  endtask
  task automatic judge(input string nm, input vec_t v, input res_t r, input bit lat, input bit any);
    int c, er;
    if (v.ew) begin
      c = any ? r.col : int'(v.ecol);
      er = any ? (c < 7 ? 5 - h[c] : 0) : int'(v.erow);
      if (any) chk({nm, " col_free"}, int'(c < 7 && h[c] < 6), 1);
      else chk({nm, " wr_col"}, r.col, int'(v.ecol));
      chk({nm, " write_seen"}, int'(r.wr_cyc >= 0), 1);
      chk({nm, " wr_row"}, r.row, er);
      chk({nm, " wr_player"}, r.pl, int'(v.epl));
      chk({nm, " wr_count"}, r.n_wr, 1);
      chk({nm, " done_after_wr"}, r.done_cyc, r.wr_cyc + 1);
      chk({nm, " invalid"}, int'(r.inv_cyc >= 0), 0);
      chk({nm, " fall_len"}, r.fall_n, (er + 1) * FT);
      chk({nm, " fall_trace"}, r.ferr, 0);
      chk({nm, " fall_col"}, r.fcol, r.col);
      chk({nm, " fall_player"}, r.fpl, r.pl);
      chk({nm, " idle_zero"}, r.zerr, 0);
      chk({nm, " full_at_wr"}, r.bf_wr, 0);
      if (lat) chk({nm, " wr_latency"}, r.wr_cyc, 2 + (er + 1) * FT);
      if (c < 7 && h[c] < 6) h[c]++;
      chk({nm, " full_after"}, r.bf_done, model_full());
    end else if (v.ei) begin
      chk({nm, " invalid_seen"}, int'(r.inv_cyc >= 0), 1);
      chk({nm, " wr_count"}, r.n_wr, 0);
      chk({nm, " done_seen"}, int'(r.done_cyc >= 0), 0);
      if (lat) chk({nm, " inv_latency"}, r.inv_cyc, 2);
    end else begin
      chk({nm, " wr_count"}, r.n_wr, 0);
      chk({nm, " invalid_seen"}, int'(r.inv_cyc >= 0), 0);
      chk({nm, " busy_cycles"}, r.n_busy, 0);
    end
  endtask
  task automatic move(input string nm, input vec_t v, input int inj, input bit lat, input bit any);
    res_t r;
    run(v, (v.ew || v.ei) ? 200 : 20, inj, r);
    judge(nm, v, r, lat, any);
  endtask
  initial begin
    vec_t v;
    bit any;
    int n, k;
    tbl[0] = mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 5, 0, 1);
    tbl[1] = mk(1, 0, 1, 0, 0, 3, 0, 1, 0, 5, 3, 1);
    for (int i = 0; i < 6; i++) tbl[2 + i] = mk(0, 1, 0, 1, 0, 0, 2, 1, 0, 5 - i, 2, 2);
    tbl[8] = mk(0, 1, 0, 1, 0, 0, 2, 0, 1, 0, 0, 0);
    tbl[9] = mk(0, 1, 0, 1, 0, 0, 7, 0, 1, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 1, 1, 0, 0, 4, 0, 1, 0, 5, 4, 1);
    repeat (3) @(negedge clk);
    chk("reset outputs", int'(outs), 0);
    rst_n = 1'b1;
    p1_turn = 1'b1; p1_col = 3'd4; p1_req = 1'b1;
    @(negedge clk);
    p1_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset fall_active", int'(fall_active), 1);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", int'(outs), 0);
    repeat (2) @(negedge clk);
    chk("reset held outputs", int'(outs), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) h[c] = 0;
    foreach (tbl[i]) move($sformatf("vec%0d", i), tbl[i], 0, 1'b1, 1'b0);
    move("req+random", mk(1, 0, 1, 0, 1, 2, 0, 1, 0, 0, 0, 1), 0, 1'b0, 1'b1);
    move("req_in_fall", mk(1, 0, 1, 0, 0, 5, 0, 1, 0, 5 - h[5], 5, 1), 6, 1'b1, 1'b0);
    move("after_req_in_fall", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1'b0, 1'b0);
    p1_turn = 1'b1; p2_turn = 1'b0; p1_col = 3'd1; p1_req = 1'b1;
    @(negedge clk);
    p1_req = 1'b0;
    k = 0;
    while (!fall_active && k < 10) begin @(negedge clk); k++; end
    chk("clear fall reached", int'(fall_active), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear busy", int'(busy), 0);
    chk("clear board_full", int'(board_full), 0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (wr_en || drop_done || busy) n++;
    end
    chk("clear no activity", n, 0);
    for (int c = 0; c < 7; c++) h[c] = 0;
    move("heights cleared", mk(1, 0, 1, 0, 0, 2, 0, 1, 0, 5, 2, 1), 0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.t1 = 1'($urandom_range(0, 1)); v.t2 = 1'($urandom_range(0, 1));
      v.r1 = 1'($urandom_range(0, 1)); v.r2 = 1'($urandom_range(0, 1));
      v.rm = 1'($urandom_range(0, 3) == 0);
      v.c1 = 3'($urandom_range(0, 7)); v.c2 = 3'($urandom_range(0, 7));
      v = predict(v, any);
      move($sformatf("rand%0d", i), v, 0, !v.rm || model_full() != 0, any);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("clear idle board_full", int'(board_full), 0);
    for (int c = 0; c < 7; c++) h[c] = 0;
    for (int c = 0; c < 6; c++)
      for (int i = 0; i < 6; i++) begin
        v = predict(mk(1, 0, 1, 0, 0, c, 0, 0, 0, 0, 0, 0), any);
        move($sformatf("fill c%0d", c), v, 0, 1'b1, 1'b0);
      end
    move("random skips full", mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 5, 6, 2), 0, 1'b0, 1'b0);
    k = 0;
    while (model_full() == 0 && k < 10) begin
      v = predict(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), any);
      move($sformatf("random fill %0d", k), v, 0, 1'b0, any);
      k++;
    end
    chk("board_full", int'(board_full), 1);
    move("random on full", mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0), 0, 1'b1, 1'b0);
    move("req on full", mk(0, 1, 0, 1, 0, 0, 6, 0, 1, 0, 0, 0), 0, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
